// File: rtl/wave_channel_scheduler_if.sv
// Config, sine-table and sample-output signals of the wave channel scheduler.
// master = surrounding system (config, table, sink); slave = scheduler.
interface wave_channel_scheduler_if #(
  parameter int NCH = 4
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [1:0]    cfg_sel;
  logic [15:0]   cfg_data;
  logic [13:0]   tbl_phase;
  logic [11:0]   tbl_result;
  logic          out_valid;
  logic [CW-1:0] out_ch;
  logic [11:0]   out_sample;
  logic          out_ready;
  logic          overrun;
  logic          clr_overrun;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_sel,
    output cfg_data,
    output tbl_result,
    output out_ready,
    output clr_overrun,
    input  tbl_phase,
    input  out_valid,
    input  out_ch,
    input  out_sample,
    input  overrun
  );

  modport slave (
    input  cfg_we,
    input  cfg_ch,
    input  cfg_sel,
    input  cfg_data,
    input  tbl_result,
    input  out_ready,
    input  clr_overrun,
    output tbl_phase,
    output out_valid,
    output out_ch,
    output out_sample,
    output overrun
  );
endinterface

// File: rtl/wave_channel_scheduler.sv
// Time-shares one sine table among NCH channels: per tick, each enabled
// channel is looked up, scaled by its amplitude and handed downstream.
module wave_channel_scheduler #(
  parameter int NCH      = 4,
  parameter int TICK_DIV = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  wave_channel_scheduler_if.slave bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMMIT,
    S_SCAN,
    S_ISSUE,
    S_CAPTURE,
    S_PRESENT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [TW-1:0] r_tcnt;
  logic [CW:0]   r_ch;
  logic [CW-1:0] w_ci;
  logic          w_tick;
  logic          w_done;
  logic          w_commit;
  logic          w_skip;
  logic          w_look;
  logic          w_cap;
  logic          w_hs;
  logic          w_cfg;

  logic [11:0]    r_amp_s [NCH];
  logic [11:0]    r_amp   [NCH];
  logic [15:0]    r_off_s [NCH];
  logic [15:0]    r_inc_s [NCH];
  logic [15:0]    r_inc   [NCH];
  logic [15:0]    r_acc   [NCH];
  logic [NCH-1:0] r_en_s;
  logic [NCH-1:0] r_en;
  logic [NCH-1:0] r_pend;

  logic [13:0]   r_tbl_phase;
  logic          r_valid;
  logic [CW-1:0] r_out_ch;
  logic [11:0]   r_sample;
  logic          r_ovr;

  assign w_ci   = r_ch[CW-1:0];
  assign w_tick = (r_tcnt == TW'(TICK_DIV - 1));
  assign w_done = (r_ch == (CW + 1)'(NCH));
  assign w_cfg  = bus.cfg_we && (int'(bus.cfg_ch) < NCH);

  assign bus.tbl_phase  = r_tbl_phase;
  assign bus.out_valid  = r_valid;
  assign bus.out_ch     = r_out_ch;
  assign bus.out_sample = r_sample;
  assign bus.overrun    = r_ovr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    w_skip   = 1'b0;
    w_look   = 1'b0;
    w_cap    = 1'b0;
    w_hs     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_commit = 1'b1;
        w_next   = S_SCAN;
      end
      S_SCAN: begin
        if (w_done) begin
          w_next = S_IDLE;
        end else if (!r_en[w_ci]) begin
          w_skip = 1'b1;
        end else begin
          w_look = 1'b1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_cap  = 1'b1;
        w_next = S_PRESENT;
      end
      S_PRESENT: begin
        if (bus.out_ready) begin
          w_hs   = 1'b1;
          w_next = S_SCAN;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt <= '0;
      r_ovr  <= 1'b0;
    end else begin
      r_tcnt <= w_tick ? '0 : r_tcnt + 1'b1;
      // A tick that finds a frame still running is dropped, not queued.
      if (w_tick && (r_state != S_IDLE)) begin
        r_ovr <= 1'b1;
      end else if (bus.clr_overrun) begin
        r_ovr <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        r_amp_s[k] <= '0;
        r_amp[k]   <= '0;
        r_off_s[k] <= '0;
        r_inc_s[k] <= '0;
        r_inc[k]   <= '0;
        r_acc[k]   <= '0;
      end
      r_en_s <= '0;
      r_en   <= '0;
      r_pend <= '0;
    end else begin
      if (w_commit) begin
        for (int k = 0; k < NCH; k++) begin
          r_amp[k] <= r_amp_s[k];
          r_inc[k] <= r_inc_s[k];
          if (r_pend[k]) begin
            r_acc[k] <= r_off_s[k];
          end
        end
        r_en   <= r_en_s;
        r_pend <= '0;
      end
      if (w_hs) begin
        r_acc[w_ci] <= r_acc[w_ci] + r_inc[w_ci];
      end
      // Placed after the commit so a write in that cycle stays pending.
      if (w_cfg) begin
        unique case (bus.cfg_sel)
          2'd0: r_amp_s[bus.cfg_ch] <= bus.cfg_data[11:0];
          2'd1: begin
            r_off_s[bus.cfg_ch] <= bus.cfg_data;
            r_pend[bus.cfg_ch]  <= 1'b1;
          end
          2'd2: r_inc_s[bus.cfg_ch] <= bus.cfg_data;
          default: r_en_s[bus.cfg_ch] <= bus.cfg_data[0];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch        <= '0;
      r_tbl_phase <= '0;
      r_valid     <= 1'b0;
      r_out_ch    <= '0;
      r_sample    <= '0;
    end else begin
      if (w_commit) begin
        r_ch <= '0;
      end else if (w_skip || w_hs) begin
        r_ch <= r_ch + 1'b1;
      end
      if (w_look) begin
        r_tbl_phase <= r_acc[w_ci][15:2];
      end
      if (w_cap) begin
        r_sample <= 12'(({12'd0, r_amp[w_ci]} *
                         {12'd0, bus.tbl_result}) >> 12);
        r_out_ch <= w_ci;
        r_valid  <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wave_channel_scheduler.sv
// Randomised bench for wave_channel_scheduler with a timeline-based model
// of frame scheduling, plus directed literal checks.
module tb_wave_channel_scheduler;
  localparam int NCH  = 4;
  localparam int TDIV = 64;
  localparam int CW   = 2;

  logic clk;
  logic rst_n;
  int   tbl_mode;
  int   total = 0;
  int   bad   = 0;

  wave_channel_scheduler_if #(.NCH(NCH)) bus ();

  wave_channel_scheduler #(
    .NCH     (NCH),
    .TICK_DIV(TDIV)
  ) dut (
    .clk    (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tbl_f(int mode, logic [13:0] ph);
    logic [11:0] v;
    case (mode)
      0:       v = ph[13:2];
      1:       v = 12'h800;
      default: v = {ph[5:0], ph[13:8]} ^ 12'h5A3;
    endcase
    return int'(v);
  endfunction

  always_comb begin
    bus.tbl_result = 12'(tbl_f(tbl_mode, bus.tbl_phase));
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_to(string nm);
    total++;
    bad++;
    $display("FAIL %s timeout act=none exp=event t=%0t", nm, $time);
  endtask

  // Model state: cycle index since reset, frame timeline, channel config.
  int          mk;
  int          m_fin;
  int          m_commit_at;
  int          m_t;
  int          m_ptr;
  bit          m_pend;
  int          m_vfrom;
  int          m_ch;
  int          m_smp;
  int          m_ph;
  bit          m_ov;
  logic [11:0] s_amp [NCH];
  logic [11:0] l_amp [NCH];
  logic [15:0] s_off [NCH];
  logic [15:0] s_inc [NCH];
  logic [15:0] l_inc [NCH];
  logic [15:0] acc   [NCH];
  bit          s_en  [NCH];
  bit          l_en  [NCH];
  bit          lp    [NCH];

  int q_k[$];
  int q_ch[$];
  int q_s[$];
  int q_p[$];

  // Next channel to serve: skipped channels cost one cycle each;
  // a served one presents three cycles after it is scanned.
  task automatic m_scan();
    while (m_ptr < NCH && !l_en[m_ptr]) begin
      m_t++;
      m_ptr++;
    end
    if (m_ptr < NCH) begin
      m_pend  = 1'b1;
      m_ch    = m_ptr;
      m_vfrom = m_t + 3;
      m_ph    = int'(acc[m_ptr][15:2]);
      m_smp   = ((int'(l_amp[m_ptr]) * tbl_f(tbl_mode, 14'(m_ph))) >> 12)
                & 'hFFF;
    end else begin
      m_pend = 1'b0;
      m_fin  = m_t;
    end
  endtask

  always @(negedge clk) begin
    bit expv;
    bit tick;
    bit busy;
    if (!rst_n) begin
      mk          = 0;
      m_fin       = -1;
      m_commit_at = -1;
      m_pend      = 1'b0;
      m_ov        = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        s_amp[i] = '0; l_amp[i] = '0; s_off[i] = '0;
        s_inc[i] = '0; l_inc[i] = '0; acc[i]   = '0;
        s_en[i]  = 1'b0; l_en[i] = 1'b0; lp[i] = 1'b0;
      end
    end else begin
      expv = m_pend && (mk >= m_vfrom);
      chk("out_valid", int'(bus.out_valid), int'(expv));
      if (expv) begin
        chk("out_ch", int'(bus.out_ch), m_ch);
        chk("out_sample", int'(bus.out_sample), m_smp);
        chk("tbl_phase", int'(bus.tbl_phase), m_ph);
      end
      chk("overrun", int'(bus.overrun), int'(m_ov));
      tick = ((mk % TDIV) == TDIV - 1);
      busy = (mk <= m_fin);
      if (tick && busy) m_ov = 1'b1;
      else if (bus.clr_overrun) m_ov = 1'b0;
      if (mk == m_commit_at) begin
        for (int i = 0; i < NCH; i++) begin
          l_amp[i] = s_amp[i];
          l_inc[i] = s_inc[i];
          l_en[i]  = s_en[i];
          if (lp[i]) begin
            acc[i] = s_off[i];
            lp[i]  = 1'b0;
          end
        end
        m_t   = mk + 1;
        m_ptr = 0;
        m_scan();
      end
      if (expv && bus.out_ready) begin
        q_k.push_back(mk);
        q_ch.push_back(int'(bus.out_ch));
        q_s.push_back(int'(bus.out_sample));
        q_p.push_back(int'(bus.tbl_phase));
        acc[m_ch] = acc[m_ch] + l_inc[m_ch];
        m_ptr++;
        m_t = mk + 1;
        m_scan();
      end
      if (bus.cfg_we) begin
        case (bus.cfg_sel)
          2'd0: s_amp[bus.cfg_ch] = bus.cfg_data[11:0];
          2'd1: begin
            s_off[bus.cfg_ch] = bus.cfg_data;
            lp[bus.cfg_ch]    = 1'b1;
          end
          2'd2: s_inc[bus.cfg_ch] = bus.cfg_data;
          default: s_en[bus.cfg_ch] = bus.cfg_data[0];
        endcase
      end
      if (tick && !busy) begin
        m_commit_at = mk + 1;
        m_fin       = 1 << 30;
      end
      mk++;
    end
  end

  task automatic cfg(int c, int s, int d);
    @(posedge clk); #1;
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = CW'(c);
    bus.cfg_sel  = 2'(s);
    bus.cfg_data = 16'(d);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic q_clear();
    q_k.delete();
    q_ch.delete();
    q_s.delete();
    q_p.delete();
  endtask

  task automatic wait_q(int n, int budget, string nm);
    for (int i = 0; i < budget; i++) begin
      if (q_k.size() >= n) return;
      @(posedge clk); #1;
    end
    fail_to(nm);
  endtask

  task automatic wait_quiet(string nm);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (mk > m_fin && (mk % TDIV) >= 20 && (mk % TDIV) < 30) return;
    end
    fail_to(nm);
  endtask

  task automatic wait_valid(int budget, string nm);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) return;
    end
    fail_to(nm);
  endtask

  int expA[4] = '{'h000, 'h03F, 'h07F, 'h0BF};

  initial begin
    rst_n           = 1'b0;
    tbl_mode        = 0;
    bus.cfg_we      = 1'b0;
    bus.cfg_ch      = '0;
    bus.cfg_sel     = '0;
    bus.cfg_data    = '0;
    bus.out_ready   = 1'b1;
    bus.clr_overrun = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_phase", int'(bus.tbl_phase), 0);
    chk("rst_ovr", int'(bus.overrun), 0);
    chk("rst_sample", int'(bus.out_sample), 0);
    chk("rst_ch", int'(bus.out_ch), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single channel ramp through an identity-like table.
    q_clear();
    cfg(0, 0, 'h0FFF);
    cfg(0, 2, 'h0400);
    cfg(0, 1, 'h0000);
    cfg(0, 3, 1);
    wait_q(4, 400, "A_frames");
    for (int i = 0; i < 4; i++) begin
      chk("A_phase", q_p[i], i * 'h100);
      chk("A_sample", q_s[i], expA[i]);
      chk("A_latency", q_k[i] % TDIV, 4);
    end

    // All channels served in order, four cycles apart.
    wait_quiet("B_quiet0");
    for (int c = 1; c < NCH; c++) begin
      cfg(c, 0, 'h400 + c * 'h111);
      cfg(c, 2, 'h0100 * c);
      cfg(c, 3, 1);
    end
    repeat (TDIV) @(posedge clk);
    wait_quiet("B_quiet1");
    q_clear();
    wait_q(4, 200, "B_frame");
    chk("B_first", q_k[0] % TDIV, 4);
    for (int i = 0; i < 4; i++) begin
      chk("B_order", q_ch[i], i);
      if (i > 0) chk("B_gap", q_k[i] - q_k[i-1], 4);
    end

    // Long downstream stall: held output, dropped ticks, overrun.
    wait_quiet("C_quiet0");
    for (int c = 1; c < NCH; c++) cfg(c, 3, 0);
    repeat (TDIV) @(posedge clk);
    wait_quiet("C_quiet1");
    q_clear();
    bus.out_ready = 1'b0;
    repeat (200) @(posedge clk);
    #2;
    chk("C_ovr", int'(bus.overrun), 1);
    chk("C_held", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    wait_q(2, 200, "C_resume");
    chk("C_acc", q_p[1], (q_p[0] + 'h100) & 'h3FFF);
    wait_quiet("C_quiet2");
    bus.clr_overrun = 1'b1;
    @(posedge clk); #1;
    bus.clr_overrun = 1'b0;
    @(posedge clk); #2;
    chk("C_clr", int'(bus.overrun), 0);

    // Accumulator wrap, then an offset written mid-frame.
    wait_quiet("D_quiet0");
    cfg(0, 2, 'hC000);
    cfg(0, 1, 'h8000);
    q_clear();
    wait_q(2, 200, "D_wrap");
    chk("D_start", q_p[0], 'h2000);
    chk("D_wrap", q_p[1], 'h1000);
    q_clear();
    bus.out_ready = 1'b0;
    wait_valid(200, "D_valid");
    cfg(0, 1, 'h1234);
    bus.out_ready = 1'b1;
    wait_q(2, 200, "D_mid");
    chk("D_cur", q_p[0], 'h0000);
    chk("D_load", q_p[1], 'h048D);

    // Fixed table value: scaling, zero amplitude, disabled channels.
    wait_quiet("E_quiet0");
    tbl_mode = 1;
    cfg(0, 0, 'h800);
    cfg(1, 0, 'h123);
    cfg(2, 0, 'h000);
    cfg(2, 2, 'h0400);
    cfg(2, 3, 1);
    cfg(3, 3, 0);
    repeat (TDIV) @(posedge clk);
    wait_quiet("E_quiet1");
    q_clear();
    wait_q(4, 200, "E_frames");
    chk("E_ch0", q_ch[0], 0);
    chk("E_ch1", q_ch[1], 2);
    chk("E_ch2", q_ch[2], 0);
    chk("E_ch3", q_ch[3], 2);
    chk("E_half", q_s[0], 'h400);
    chk("E_zero", q_s[1], 0);
    chk("E_adv", q_p[3], (q_p[1] + 'h100) & 'h3FFF);

    // Random traffic against the model.
    wait_quiet("F_quiet");
    tbl_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.out_ready   = (($urandom % 4) != 0);
      bus.clr_overrun = (($urandom % 50) == 0);
      bus.cfg_we      = (($urandom % 8) == 0);
      bus.cfg_ch      = CW'($urandom % NCH);
      bus.cfg_sel     = 2'($urandom % 4);
      bus.cfg_data    = 16'($urandom);
    end
    @(posedge clk); #1;
    bus.cfg_we      = 1'b0;
    bus.clr_overrun = 1'b0;
    bus.out_ready   = 1'b1;

    // Asynchronous reset while a sample is being presented.
    wait_quiet("G_quiet");
    tbl_mode = 1;
    cfg(0, 0, 'hFFF);
    cfg(0, 3, 1);
    bus.out_ready = 1'b0;
    wait_valid(200, "G_valid");
    repeat (70) @(posedge clk);
    #2;
    chk("G_pre_ovr", int'(bus.overrun), 1);
    chk("G_pre_smp", int'(bus.out_sample), 'h7FF);
    rst_n = 1'b0;
    #1;
    chk("G_valid", int'(bus.out_valid), 0);
    chk("G_sample", int'(bus.out_sample), 0);
    chk("G_ovr", int'(bus.overrun), 0);
    chk("G_phase", int'(bus.tbl_phase), 0);
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    repeat (150) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
